// File: rtl/fetch_pc_pkg.sv
// fetch_pc shared types and defaults.
// State and next-PC select encodings.
package fetch_pc_pkg;

  localparam logic [31:0] PC_RESET_DFLT = 32'h0000_3000;
  localparam int          ADDR_W_DFLT   = 10;

  typedef enum logic [1:0] {
    RUN,
    HALTED,
    FAULT
  } state_e;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_J,
    SEL_JR,
    SEL_PEND
  } sel_e;

endpackage

// File: rtl/fetch_pc_npc.sv
// Next-PC target computation, priority select
// and imem range/alignment check.
module fetch_pc_npc
  import fetch_pc_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DFLT,
  parameter int          ADDR_W   = ADDR_W_DFLT
) (
  input  logic [31:0] pc_plus4,
  input  logic        br_taken,
  input  logic [15:0] br_imm,
  input  logic        j_en,
  input  logic [25:0] j_index,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  input  logic        pend_v,
  input  logic [31:0] pend_pc,
  output logic        redir,
  output sel_e        sel,
  output logic [31:0] next_pc,
  output logic        legal
);

  localparam logic [31:0] PC_END =
    PC_RESET + (32'd4 << ADDR_W);

  logic [31:0] br_tgt;
  logic [31:0] j_tgt;

  // Targets, fresh-over-pending priority, and the selected PC.
  always_comb begin
    br_tgt = pc_plus4 +
      {{14{br_imm[15]}}, br_imm, 2'b00};
    j_tgt  = {pc_plus4[31:28], j_index, 2'b00};
    redir  = jr_en | j_en | br_taken;
    if (jr_en)         sel = SEL_JR;
    else if (j_en)     sel = SEL_J;
    else if (br_taken) sel = SEL_BR;
    else if (pend_v)   sel = SEL_PEND;
    else               sel = SEL_SEQ;
    unique case (sel)
      SEL_JR:   next_pc = jr_target;
      SEL_J:    next_pc = j_tgt;
      SEL_BR:   next_pc = br_tgt;
      SEL_PEND: next_pc = pend_pc;
      default:  next_pc = pc_plus4;
    endcase
    legal = (next_pc >= PC_RESET) &&
            (next_pc < PC_END) &&
            (next_pc[1:0] == 2'b00);
  end

endmodule

// File: rtl/fetch_pc.sv
// Program counter stage: holds pc, deferred
// redirect, run/halt/fault state; drives imem addr.
module fetch_pc
  import fetch_pc_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DFLT,
  parameter int          ADDR_W   = ADDR_W_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [15:0]       br_imm,
  input  logic              j_en,
  input  logic [25:0]       j_index,
  input  logic              jr_en,
  input  logic [31:0]       jr_target,
  input  logic              halt,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic [ADDR_W-1:0] addr,
  output logic              fetch_valid,
  output logic              fault
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        fault_q, fault_d;

  logic        redir;
  sel_e        sel;
  logic [31:0] next_pc;
  logic        legal;
  logic [31:0] off;
  logic        unused_bits;

  fetch_pc_npc #(
    .PC_RESET (PC_RESET),
    .ADDR_W   (ADDR_W)
  ) u_npc (
    .pc_plus4  (pc_plus4),
    .br_taken  (br_taken),
    .br_imm    (br_imm),
    .j_en      (j_en),
    .j_index   (j_index),
    .jr_en     (jr_en),
    .jr_target (jr_target),
    .pend_v    (pend_v_q),
    .pend_pc   (pend_pc_q),
    .redir     (redir),
    .sel       (sel),
    .next_pc   (next_pc),
    .legal     (legal)
  );

  // Stall defers redirects; fault beats halt beats update.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_v_d  = pend_v_q;
    pend_pc_d = pend_pc_q;
    fault_d   = fault_q;
    if (state_q == RUN) begin
      if (stall) begin
        if (redir) begin
          pend_v_d  = 1'b1;
          pend_pc_d = next_pc;
        end
      end else if (!legal) begin
        state_d  = FAULT;
        fault_d  = 1'b1;
        pend_v_d = 1'b0;
      end else if (halt) begin
        state_d  = HALTED;
        pend_v_d = 1'b0;
      end else begin
        pc_d     = next_pc;
        pend_v_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= PC_RESET;
      pend_v_q  <= 1'b0;
      pend_pc_q <= PC_RESET;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_v_q  <= pend_v_d;
      pend_pc_q <= pend_pc_d;
      fault_q   <= fault_d;
    end
  end

  assign off         = pc_q - PC_RESET;
  assign unused_bits = ^{off[31:ADDR_W+2], off[1:0], sel};
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign addr        = off[ADDR_W+1:2];
  assign fetch_valid = (state_q == RUN) && !reset;
  assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_pc.sv
// Scoreboard bench for fetch_pc: driver queues
// expected per-cycle outputs, monitor compares.
module tb_fetch_pc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_imm = '0;
  logic        j_en = 1'b0;
  logic [25:0] j_index = '0;
  logic        jr_en = 1'b0;
  logic [31:0] jr_target = '0;
  logic        halt = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [9:0]  addr;
  logic        fetch_valid;
  logic        fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [9:0]  addr;
    logic        fv;
    logic        flt;
  } exp_t;

  exp_t sb[$];

  fetch_pc dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_imm      (br_imm),
    .j_en        (j_en),
    .j_index     (j_index),
    .jr_en       (jr_en),
    .jr_target   (jr_target),
    .halt        (halt),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .addr        (addr),
    .fetch_valid (fetch_valid),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Monitor: one expected entry per cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pc", pc, e.pc);
      chk("pc_plus4", pc_plus4, e.pc + 32'd4);
      chk("addr", {22'd0, addr}, {22'd0, e.addr});
      chk("fetch_valid", {31'd0, fetch_valid},
          {31'd0, e.fv});
      chk("fault", {31'd0, fault}, {31'd0, e.flt});
    end
  end

  // epc/efv/eflt: outputs expected this cycle;
  // op/v: inputs applied for the coming edge.
  task automatic step(input logic [31:0] epc,
                      input logic efv,
                      input logic eflt,
                      input string op,
                      input logic [31:0] v);
    exp_t e;
    @(posedge clk);
    #1;
    reset = 0; stall = 0; br_taken = 0;
    br_imm = '0; j_en = 0; j_index = '0;
    jr_en = 0; jr_target = '0; halt = 0;
    case (op)
      "rst": reset = 1;
      "br": begin br_taken = 1; br_imm = v[15:0]; end
      "j": begin j_en = 1; j_index = v[25:0]; end
      "jr": begin jr_en = 1; jr_target = v; end
      "stall": stall = 1;
      "stall_jr": begin
        stall = 1; jr_en = 1; jr_target = v;
      end
      "stall_halt": begin stall = 1; halt = 1; end
      "halt_br": begin
        halt = 1; br_taken = 1; br_imm = v[15:0];
      end
      "halt_jr": begin
        halt = 1; jr_en = 1; jr_target = v;
      end
      default: ;
    endcase
    e.pc   = epc;
    e.addr = 10'((epc - 32'h3000) >> 2);
    e.fv   = efv;
    e.flt  = eflt;
    sb.push_back(e);
  endtask

  initial begin
    step(32'h3000, 0, 0, "rst", 0);
    step(32'h3000, 1, 0, "idle", 0);
    step(32'h3004, 1, 0, "idle", 0);
    step(32'h3008, 1, 0, "br", 32'hFFFF);
    step(32'h3008, 1, 0, "j", 32'h0C04);
    step(32'h3010, 1, 0, "idle", 0);
    step(32'h3014, 0, 0, "rst", 0);
    step(32'h3000, 1, 0, "idle", 0);
    step(32'h3004, 1, 0, "stall_jr", 32'h3020);
    step(32'h3004, 1, 0, "stall", 0);
    step(32'h3004, 1, 0, "idle", 0);
    step(32'h3020, 1, 0, "stall_jr", 32'h3040);
    step(32'h3020, 1, 0, "br", 32'h0002);
    step(32'h302C, 1, 0, "idle", 0);
    step(32'h3030, 1, 0, "stall_jr", 32'h3100);
    step(32'h3030, 1, 0, "stall_jr", 32'h3200);
    step(32'h3030, 1, 0, "idle", 0);
    step(32'h3200, 1, 0, "stall_halt", 0);
    step(32'h3200, 1, 0, "idle", 0);
    step(32'h3204, 1, 0, "jr", 32'h3022);
    step(32'h3204, 0, 1, "idle", 0);
    step(32'h3204, 0, 1, "jr", 32'h3000);
    step(32'h3204, 0, 1, "rst", 0);
    step(32'h3000, 1, 0, "jr", 32'h2FFC);
    step(32'h3000, 0, 1, "rst", 0);
    step(32'h3000, 1, 0, "jr", 32'h3FF8);
    step(32'h3FF8, 1, 0, "idle", 0);
    step(32'h3FFC, 1, 0, "idle", 0);
    step(32'h3FFC, 0, 1, "rst", 0);
    step(32'h3000, 1, 0, "j", 32'h0C04);
    step(32'h3010, 1, 0, "halt_br", 32'h0005);
    for (int i = 0; i < 4; i++)
      step(32'h3010, 0, 0, "idle", 0);
    step(32'h3010, 0, 0, "rst", 0);
    step(32'h3000, 1, 0, "halt_jr", 32'h3022);
    step(32'h3000, 0, 1, "rst", 0);
    step(32'h3000, 1, 0, "stall_jr", 32'h3100);
    step(32'h3000, 0, 0, "rst", 0);
    step(32'h3000, 1, 0, "idle", 0);
    step(32'h3004, 1, 0, "idle", 0);
    for (int i = 0; i < 4 && sb.size() > 0; i++)
      @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d left expected 0",
               sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
